// File: rtl/storage_access_arbiter.sv
// Round-robin burst arbiter sharing one single-port storage RAM among page controllers.
// Sequences one RAM access per cycle and steers read data back to the burst owner.
module storage_access_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned RAM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     sys_rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*LEN_W-1:0]   len,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         beat,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         abort,
  output logic                     busy,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata
);

  localparam int unsigned OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t             state;
  logic [OWN_W-1:0]   owner;
  logic [N_REQ-1:0]   own_oh;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic               aborting;
  logic [N_REQ-1:0]   pipe [RAM_LAT];

  logic [ADDR_W-1:0]  addr_a  [N_REQ];
  logic [LEN_W-1:0]   len_a   [N_REQ];
  logic [DATA_W-1:0]  wdata_a [N_REQ];

  logic [OWN_W-1:0]   pick;
  logic [OWN_W-1:0]   cand;
  logic               pick_vld;
  logic [N_REQ-1:0]   pick_oh;
  logic [N_REQ-1:0]   pipe_in;
  logic               pend_low;
  logic               pend_all;

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
      len_a[i]   = len[i*LEN_W +: LEN_W];
      wdata_a[i] = wdata[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick starting one past the last owner
  always_comb begin
    pick     = '0;
    cand     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      cand = OWN_W'((32'(owner) + 32'(i)) % N_REQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
    pick_oh = N_REQ'(1) << pick;
  end

  // Reads still in flight after this edge: below the last stage, and anywhere
  assign pipe_in = ram_we ? '0 : beat;
  always_comb begin
    pend_all = |pipe_in;
    pend_low = (RAM_LAT > 1) && (|pipe_in);
    for (int j = 1; j < int'(RAM_LAT); j++) begin
      pend_all = pend_all | (|pipe[j-1]);
      if (j < int'(RAM_LAT) - 1) pend_low = pend_low | (|pipe[j-1]);
    end
  end

  assign rvalid = pipe[RAM_LAT-1];
  assign rdata  = (|rvalid) ? ram_rdata : '0;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      owner     <= OWN_W'(N_REQ - 1);
      own_oh    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      aborting  <= 1'b0;
      gnt       <= '0;
      beat      <= '0;
      done      <= '0;
      abort     <= '0;
      busy      <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      for (int j = 0; j < int'(RAM_LAT); j++) pipe[j] <= '0;
    end else begin
      gnt    <= '0;
      beat   <= '0;
      done   <= '0;
      abort  <= '0;
      ram_en <= 1'b0;
      pipe[0] <= pipe_in;
      for (int j = 1; j < int'(RAM_LAT); j++) pipe[j] <= pipe[j-1];

      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner     <= pick;
            own_oh    <= pick_oh;
            len_q     <= len_a[pick];
            cnt       <= '0;
            aborting  <= 1'b0;
            gnt       <= pick_oh;
            beat      <= pick_oh;
            busy      <= 1'b1;
            ram_en    <= 1'b1;
            ram_we    <= we[pick];
            ram_addr  <= addr_a[pick];
            ram_wdata <= wdata_a[pick];
            state     <= BURST;
          end
        end
        BURST: begin
          if (cnt == len_q) begin
            ram_we <= 1'b0;
            if (!pend_low) begin
              done  <= own_oh;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (!req[owner]) begin
            // Withdrawn: stop issuing, let issued reads return, then abort
            ram_we   <= 1'b0;
            aborting <= 1'b1;
            if (!pend_all) begin
              abort <= own_oh;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt       <= cnt + LEN_W'(1);
            ram_en    <= 1'b1;
            ram_addr  <= ram_addr + ADDR_W'(1);
            ram_wdata <= wdata_a[owner];
            beat      <= own_oh;
          end
        end
        DRAIN: begin
          if (aborting) begin
            if (!pend_all) begin
              abort <= own_oh;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (!pend_low) begin
            done  <= own_oh;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_storage_access_arbiter.sv
// Directed bench for storage_access_arbiter: per-cycle expectation tables against a 2-cycle RAM model.
module tb_storage_access_arbiter;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  req, we;
  logic [29:0] addr;
  logic [11:0] len;
  logic [47:0] wdata;
  logic [2:0]  gnt, beat, rvalid, done, abort;
  logic [15:0] rdata;
  logic        busy, ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  int n_chk = 0;
  int n_err = 0;

  storage_access_arbiter dut (
    .clk(clk), .sys_rst(sys_rst), .req(req), .we(we), .addr(addr), .len(len),
    .wdata(wdata), .gnt(gnt), .beat(beat), .rvalid(rvalid), .rdata(rdata),
    .done(done), .abort(abort), .busy(busy), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: read data valid two cycles after the ram_en cycle
  logic [15:0] mem  [1024];
  bit          wvld [1024];
  logic [15:0] rd_s1;

  function automatic logic [15:0] pre(input logic [9:0] a);
    if (a >= 10'h010 && a < 10'h018) return 16'h00A0 + 16'(a - 10'h010);
    if (a >= 10'h020 && a < 10'h028) return 16'h00C0 + 16'(a - 10'h020);
    if (a == 10'h100) return 16'h00B0;
    if (a == 10'h200) return 16'h00B1;
    if (a == 10'h300) return 16'h00B2;
    return 16'hDEAD;
  endfunction

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr]  <= ram_wdata;
      wvld[ram_addr] <= 1'b1;
    end
    if (ram_en && !ram_we) rd_s1 <= wvld[ram_addr] ? mem[ram_addr] : pre(ram_addr);
    ram_rdata <= rd_s1;
  end

  typedef struct packed {
    logic [2:0]  g, b, rv, d, a;
    logic        bz, en, w;
    logic [9:0]  ad;
    logic [15:0] wd, rd;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [2:0] N = 3'b000, R0 = 3'b001, R1 = 3'b010, R2 = 3'b100;
  localparam logic H = 1'b1, L = 1'b0;

  function automatic exp_t ex(input logic [2:0] g, b, rv, d, a, input logic bz, en, w,
                              input logic [9:0] ad, input logic [15:0] wd, rd);
    exp_t e;
    e.g = g; e.b = b; e.rv = rv; e.d = d; e.a = a;
    e.bz = bz; e.en = en; e.w = w; e.ad = ad; e.wd = wd; e.rd = rd;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [9:0] a,
                         input logic [3:0] l, input logic [15:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*10 +: 10] = a;
    len[i*4 +: 4]    = l;
    wdata[i*16 +: 16] = d;
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(ex(N, N, N, N, N, L, L, L, 10'h0, 16'h0, 16'h0));
  endtask

  // One table row per cycle, sampled 1 time unit after the rising edge
  task automatic run(input string name, input int drop_t, input int drop_i);
    exp_t e;
    for (int t = 0; t < exp_q.size(); t++) begin
      @(posedge clk);
      #1;
      e = exp_q[t];
      chk($sformatf("%s t%0d ctl", name, t), 64'({gnt, beat, rvalid, done, abort, busy, ram_en}),
          64'({e.g, e.b, e.rv, e.d, e.a, e.bz, e.en}));
      if (e.en) chk($sformatf("%s t%0d ram", name, t), 64'({ram_we, ram_addr}), 64'({e.w, e.ad}));
      if (e.en && e.w) chk($sformatf("%s t%0d wdata", name, t), 64'(ram_wdata), 64'(e.wd));
      if (e.rv != 3'b000) chk($sformatf("%s t%0d rdata", name, t), 64'(rdata), 64'(e.rd));
      for (int i = 0; i < 3; i++) begin
        if (done[i] || abort[i]) req[i] = 1'b0;
        if (beat[i] && we[i]) wdata[i*16 +: 16] = wdata[i*16 +: 16] + 16'h11;
      end
      if (t == drop_t) req[drop_i] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({gnt, beat, rvalid, done, abort, busy, ram_en, ram_we, ram_addr, ram_wdata, rdata}), 64'(0));
  endtask

  initial begin
    req = '0; we = '0; addr = '0; len = '0; wdata = '0;
    sys_rst = 1'b0;
    #2 sys_rst = 1'b1;
    #1 chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    sys_rst = 1'b0;

    // Single read of 4 words by requester 1
    set_req(1, 1'b0, 10'h010, 4'd3, 16'h0);
    exp_q.push_back(ex(R1, R1, N,  N,  N, H, H, L, 10'h010, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  R1, N,  N,  N, H, H, L, 10'h011, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  R1, R1, N,  N, H, H, L, 10'h012, 16'h0, 16'h00A0));
    exp_q.push_back(ex(N,  R1, R1, N,  N, H, H, L, 10'h013, 16'h0, 16'h00A1));
    exp_q.push_back(ex(N,  N,  R1, N,  N, H, L, L, 10'h0,   16'h0, 16'h00A2));
    exp_q.push_back(ex(N,  N,  R1, R1, N, L, L, L, 10'h0,   16'h0, 16'h00A3));
    push_idle(2);
    run("read", -1, 0);

    // Write burst wrapping past the top of the address space
    set_req(2, 1'b1, 10'h3FE, 4'd2, 16'h0011);
    exp_q.push_back(ex(R2, R2, N, N,  N, H, H, H, 10'h3FE, 16'h0011, 16'h0));
    exp_q.push_back(ex(N,  R2, N, N,  N, H, H, H, 10'h3FF, 16'h0022, 16'h0));
    exp_q.push_back(ex(N,  R2, N, N,  N, H, H, H, 10'h000, 16'h0033, 16'h0));
    exp_q.push_back(ex(N,  N,  N, R2, N, L, L, L, 10'h0,   16'h0,    16'h0));
    push_idle(2);
    run("write", -1, 0);
    chk("mem 3FE", 64'(mem[10'h3FE]), 64'h11);
    chk("mem 3FF", 64'(mem[10'h3FF]), 64'h22);
    chk("mem 000", 64'(mem[10'h000]), 64'h33);

    // Contention straight out of reset
    sys_rst = 1'b1;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    set_req(0, 1'b0, 10'h100, 4'd0, 16'h0);
    set_req(1, 1'b0, 10'h200, 4'd0, 16'h0);
    set_req(2, 1'b0, 10'h300, 4'd0, 16'h0);
    exp_q.push_back(ex(R0, R0, N,  N,  N, H, H, L, 10'h100, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  N,  N,  N, H, L, L, 10'h0,   16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  R0, R0, N, L, L, L, 10'h0,   16'h0, 16'h00B0));
    exp_q.push_back(ex(R1, R1, N,  N,  N, H, H, L, 10'h200, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  N,  N,  N, H, L, L, 10'h0,   16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  R1, R1, N, L, L, L, 10'h0,   16'h0, 16'h00B1));
    exp_q.push_back(ex(R2, R2, N,  N,  N, H, H, L, 10'h300, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  N,  N,  N, H, L, L, 10'h0,   16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  R2, R2, N, L, L, L, 10'h0,   16'h0, 16'h00B2));
    push_idle(2);
    run("contend", -1, 0);

    // Fairness: after owner 1, requester 2 goes ahead of requester 0
    set_req(1, 1'b0, 10'h200, 4'd0, 16'h0);
    exp_q.push_back(ex(R1, R1, N,  N,  N, H, H, L, 10'h200, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  N,  N,  N, H, L, L, 10'h0,   16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  R1, R1, N, L, L, L, 10'h0,   16'h0, 16'h00B1));
    push_idle(1);
    run("rr1", -1, 0);
    set_req(0, 1'b0, 10'h100, 4'd0, 16'h0);
    set_req(2, 1'b0, 10'h300, 4'd0, 16'h0);
    exp_q.push_back(ex(R2, R2, N,  N,  N, H, H, L, 10'h300, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  N,  N,  N, H, L, L, 10'h0,   16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  R2, R2, N, L, L, L, 10'h0,   16'h0, 16'h00B2));
    exp_q.push_back(ex(R0, R0, N,  N,  N, H, H, L, 10'h100, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  N,  N,  N, H, L, L, 10'h0,   16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  R0, R0, N, L, L, L, 10'h0,   16'h0, 16'h00B0));
    push_idle(1);
    run("rr2", -1, 0);

    // Abort after the third beat of an 8-word read; requester 2 follows
    set_req(1, 1'b0, 10'h020, 4'd7, 16'h0);
    set_req(2, 1'b0, 10'h300, 4'd0, 16'h0);
    exp_q.push_back(ex(R1, R1, N,  N,  N,  H, H, L, 10'h020, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  R1, N,  N,  N,  H, H, L, 10'h021, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  R1, R1, N,  N,  H, H, L, 10'h022, 16'h0, 16'h00C0));
    exp_q.push_back(ex(N,  N,  R1, N,  N,  H, L, L, 10'h0,   16'h0, 16'h00C1));
    exp_q.push_back(ex(N,  N,  R1, N,  N,  H, L, L, 10'h0,   16'h0, 16'h00C2));
    exp_q.push_back(ex(N,  N,  N,  N,  R1, L, L, L, 10'h0,   16'h0, 16'h0));
    exp_q.push_back(ex(R2, R2, N,  N,  N,  H, H, L, 10'h300, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  N,  N,  N,  H, L, L, 10'h0,   16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  R2, R2, N,  L, L, L, 10'h0,   16'h0, 16'h00B2));
    push_idle(1);
    run("abort", 2, 1);

    // Reset during the second beat of a read by requester 1
    set_req(1, 1'b0, 10'h010, 4'd3, 16'h0);
    exp_q.push_back(ex(R1, R1, N, N, N, H, H, L, 10'h010, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  R1, N, N, N, H, H, L, 10'h011, 16'h0, 16'h0));
    run("rstmid", -1, 0);
    #1 sys_rst = 1'b1;
    #1 chk_all_zero("rstmid async");
    req = '0;
    @(posedge clk); @(posedge clk); #1;
    sys_rst = 1'b0;
    push_idle(5);
    run("rstquiet", -1, 0);
    set_req(0, 1'b0, 10'h100, 4'd0, 16'h0);
    set_req(2, 1'b0, 10'h300, 4'd0, 16'h0);
    exp_q.push_back(ex(R0, R0, N,  N,  N, H, H, L, 10'h100, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  N,  N,  N, H, L, L, 10'h0,   16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  R0, R0, N, L, L, L, 10'h0,   16'h0, 16'h00B0));
    exp_q.push_back(ex(R2, R2, N,  N,  N, H, H, L, 10'h300, 16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  N,  N,  N, H, L, L, 10'h0,   16'h0, 16'h0));
    exp_q.push_back(ex(N,  N,  R2, R2, N, L, L, L, 10'h0,   16'h0, 16'h00B2));
    push_idle(1);
    run("rstnext", -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/storage_access_arbiter.md
# storage_access_arbiter

Shares one single-port storage RAM among several page controllers (menu chart reads, history record reads, play-page chart/record writes). Each requester issues one burst of consecutive words. The arbiter grants bursts round-robin, sequences one RAM access per clk cycle and steers read data back to the owner. It replaces the pattern in which pages drive read/write ids directly. It sits between the page controllers and the chart/record storage RAM on the system clock domain.

## Interface
Parameters:
- N_REQ, 3, number of requesters
- ADDR_W, 10, RAM word address width
- DATA_W, 16, RAM word width
- LEN_W, 4, burst length field width; burst = len+1 words (1..16)
- RAM_LAT, 2, RAM read latency in cycles (ram_en cycle to ram_rdata valid), ≥1

Ports:
- clk  in  1  system clock
- sys_rst  in  1  reset, asynchronous, active-high
- req  in  N_REQ  per-requester burst request, level
- we  in  N_REQ  per-requester direction, 1 = write
- addr  in  N_REQ×ADDR_W  burst base address
- len  in  N_REQ×LEN_W  burst length minus one
- wdata  in  N_REQ×DATA_W  write word for the current beat
- gnt  out  N_REQ  one-cycle pulse at burst start
- beat  out  N_REQ  pulse per issued RAM access; a write requester advances wdata after each beat
- rvalid  out  N_REQ  pulse per returned read word
- rdata  out  DATA_W  read word, shared; valid only with rvalid
- done  out  N_REQ  one-cycle pulse on normal burst completion
- abort  out  N_REQ  one-cycle pulse on requester-withdrawn burst
- busy  out  1  high whenever state ≠ IDLE
- ram_en, ram_we  out  1 each  RAM strobe, write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data

## Operation
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - If any req is set, select the owner by round-robin starting at last_owner+1 (mod N_REQ). last_owner resets to N_REQ-1, so requester 0 wins first.
  - Latch the owner's we, addr and len; beat counter = 0; go to BURST.
- BURST:
  - Each cycle: ram_en=1, ram_we=latched we, ram_addr = base+cnt (mod 2^ADDR_W, wraps silently), ram_wdata = wdata[owner], beat[owner]=1.
  - The first cycle of BURST also pulses gnt[owner].
  - After beat cnt==len: write burst → done[owner] next cycle, go IDLE. Read burst → go DRAIN.
- DRAIN:
  - Wait until the last outstanding read returns.
  - done[owner] pulses in the same cycle as the final rvalid, then go IDLE.
- Read return: a delay line of depth RAM_LAT tags each issued read with its owner. rvalid[tag] and rdata=ram_rdata are driven RAM_LAT cycles after the ram_en cycle.
- Abort:
  - If req[owner] is 0 during BURST, issue no further beats; the beat in progress in that cycle is suppressed.
  - Reads already issued still return with rvalid.
  - abort[owner] pulses once all outstanding reads have returned (next cycle if none are outstanding); then go IDLE. done is not asserted.
- Inputs of a requester that is not the owner are ignored; a req change during another burst only affects the next arbitration.
- last_owner is updated at every grant.

## Timing
- Reset values: all outputs 0, state IDLE, delay line cleared, last_owner=N_REQ-1.
- Reset mid-burst: immediate return to IDLE, pending rvalid discarded, no done/abort.
- Grant latency: req sampled high at edge k in IDLE → gnt and first beat during cycle k+1.
- Beats are back-to-back: a burst of L words occupies L consecutive cycles.
- Write done: cycle after the last beat. Read done: last beat cycle + RAM_LAT.
- IDLE always lasts ≥1 cycle between bursts, giving a minimum 1-cycle gap in ram_en.
- Simultaneous requests: only one owner per arbitration; the others wait in fairness order. Starvation bound: N_REQ-1 bursts.
- len field is latched at grant; changes afterwards have no effect.

## Test plan
- Single read: req[1], addr=0x010, len=3, RAM preloaded with 0xA0..0xA3 → gnt[1] at k+1; ram_addr 0x010..0x013 over 4 cycles; rvalid[1] with 0xA0..0xA3 from k+1+RAM_LAT; done[1] with the last rvalid.
- Write burst: req[2], we=1, addr=0x3FE, len=2, wdata stepping 0x11,0x22,0x33 on beat → RAM writes 0x3FE,0x3FF,0x000 (wrap); done[2] one cycle after the third beat.
- Contention: req[0..2] all high at the same edge from reset, len=0 each → grants in order 0,1,2; each gnt separated by ≥1 IDLE cycle; no overlapping ram_en owners.
- Round-robin fairness: last owner 1, req[0] and req[2] both high → requester 2 is granted before requester 0.
- Abort: read with len=7 and req dropped after the 3rd beat → exactly 3 rvalid, abort pulse after the last of them, no done, next requester granted afterwards.
- Reset mid-burst: assert sys_rst during the 2nd beat of a read → all outputs 0 asynchronously, no rvalid after release, requester 0 wins the next arbitration.
